// File: rtl/dmem_pkg.sv
// Shared types, transfer-size constants and size helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} dmem_state_t;

  localparam int unsigned SZ_B = 1;
  localparam int unsigned SZ_H = 2;
  localparam int unsigned SZ_W = 4;
  localparam int unsigned SZ_D = 8;

  function automatic logic size_legal(input logic [3:0] size);
    return (size == 4'(SZ_B)) || (size == 4'(SZ_H)) ||
           (size == 4'(SZ_W)) || (size == 4'(SZ_D));
  endfunction

  // Byte-lane mask for a transfer of the given size, anchored at lane 0.
  function automatic logic [7:0] size_byte_mask(input logic [3:0] size);
    logic [7:0] m;
    m = 8'h00;
    if (size == 4'(SZ_B)) m = 8'h01;
    if (size == 4'(SZ_H)) m = 8'h03;
    if (size == 4'(SZ_W)) m = 8'h0F;
    if (size == 4'(SZ_D)) m = 8'hFF;
    return m;
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Byte storage organised as 8-byte rows: byte-enable synchronous write, combinational row read.
module dmem_byte_array #(
  parameter int unsigned DEPTH_BYTES = 1024
) (
  input  logic                              clk,
  input  logic [$clog2(DEPTH_BYTES)-4:0]    base,
  input  logic [7:0]                        wr_be,
  input  logic [63:0]                       wdata,
  output logic [63:0]                       rdata
);

  localparam int unsigned ROWS = DEPTH_BYTES / 8;

  logic [63:0] mem [ROWS];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (wr_be[i]) mem[base][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[base];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding load/store, fixed-latency valid/ready response.
module dmem_responder #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [3:0]  req_size,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);
  import dmem_pkg::*;

  localparam int unsigned AW       = $clog2(DEPTH_BYTES);
  localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  dmem_state_t  state;
  logic [3:0]   cnt;
  logic [AW-1:0] a_addr;
  logic [3:0]   a_size;
  logic         a_write;
  logic [63:0]  a_wdata;
  logic         a_err;

  logic [64:0]  req_end_c;
  logic         req_err_c;
  logic [AW-1:0] cur_addr_c;
  logic [3:0]   cur_size_c;
  logic         cur_write_c;
  logic [63:0]  cur_wdata_c;
  logic         cur_err_c;
  logic         commit_c;
  logic [7:0]   size_mask_c;
  logic [7:0]   wr_be_c;
  logic [63:0]  lane_mask_c;
  logic [63:0]  arr_rdata;
  logic [63:0]  wr_data_c;
  logic [63:0]  resp_data_c;

  assign req_ready = (state == S_IDLE) && reset;

  // Legality of the request on the bus, evaluated at accept with full-width address.
  always_comb begin
    req_end_c = {1'b0, req_addr} + 65'(req_size);
    req_err_c = !size_legal(req_size) ||
                ((req_addr[3:0] & (req_size - 4'd1)) != 4'd0) ||
                (req_end_c > 65'(DEPTH_BYTES));
  end

  // In S_IDLE the commit can only be the zero-latency case, which uses the live request.
  always_comb begin
    cur_addr_c  = a_addr;
    cur_size_c  = a_size;
    cur_write_c = a_write;
    cur_wdata_c = a_wdata;
    cur_err_c   = a_err;
    if (state == S_IDLE) begin
      cur_addr_c  = req_addr[AW-1:0];
      cur_size_c  = req_size;
      cur_write_c = req_write;
      cur_wdata_c = req_wdata;
      cur_err_c   = req_err_c;
    end
    if (LATENCY == 0) commit_c = req_valid && req_ready;
    else              commit_c = (state == S_WAIT) && (cnt == 4'd0);
  end

  // Lane shifting, masking and zero-extension around the aligned 8-byte row.
  always_comb begin
    size_mask_c = size_byte_mask(cur_size_c);
    lane_mask_c = '0;
    for (int i = 0; i < 8; i++) lane_mask_c[8*i +: 8] = {8{size_mask_c[i]}};
    wr_data_c   = cur_wdata_c << {cur_addr_c[2:0], 3'b000};
    wr_be_c     = 8'h00;
    if (commit_c && cur_write_c && !cur_err_c) wr_be_c = size_mask_c << cur_addr_c[2:0];
    resp_data_c = 64'd0;
    if (!cur_write_c && !cur_err_c)
      resp_data_c = (arr_rdata >> {cur_addr_c[2:0], 3'b000}) & lane_mask_c;
  end

  dmem_byte_array #(.DEPTH_BYTES(DEPTH_BYTES)) u_array (
    .clk   (clk),
    .base  (cur_addr_c[AW-1:3]),
    .wr_be (wr_be_c),
    .wdata (wr_data_c),
    .rdata (arr_rdata)
  );

  // Request/wait/response sequencing with registered response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      a_addr     <= '0;
      a_size     <= 4'd0;
      a_write    <= 1'b0;
      a_wdata    <= 64'd0;
      a_err      <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 64'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            a_addr  <= req_addr[AW-1:0];
            a_size  <= req_size;
            a_write <= req_write;
            a_wdata <= req_wdata;
            a_err   <= req_err_c;
            if (LATENCY == 0) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= cur_err_c;
              resp_rdata <= resp_data_c;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= cur_err_c;
            resp_rdata <= resp_data_c;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 64'd0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder: byte-array reference model plus a per-cycle compare process.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
  logic [63:0] req_addr, req_wdata, resp_rdata;
  logic [3:0]  req_size;

  logic        reset3, req_valid3, req_ready3, req_write3, resp_valid3, resp_ready3, resp_err3;
  logic [63:0] req_addr3, req_wdata3, resp_rdata3;
  logic [3:0]  req_size3;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset3), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_write(req_write3), .req_addr(req_addr3), .req_wdata(req_wdata3), .req_size(req_size3),
    .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_rdata(resp_rdata3), .resp_err(resp_err3)
  );

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, want 0x%h at %0t", nm, act, exp, $time);
  endfunction

  // Reference memory: plain byte array, little-endian.
  logic [7:0] mdl [DEPTH];

  function automatic logic mdl_legal(input logic [63:0] a, input logic [3:0] s);
    if (!(s == 4'd1 || s == 4'd2 || s == 4'd4 || s == 4'd8)) return 1'b0;
    if ((a % 64'(s)) != 64'd0) return 1'b0;
    if (a > 64'(DEPTH) - 64'(s)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [63:0] mdl_load(input logic [63:0] a, input logic [3:0] s);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < int'(s); i++) r[8*i +: 8] = mdl[a[9:0] + 10'(i)];
    return r;
  endfunction

  function automatic void mdl_store(input logic [63:0] a, input logic [3:0] s, input logic [63:0] d);
    for (int i = 0; i < int'(s); i++) mdl[a[9:0] + 10'(i)] = d[8*i +: 8];
  endfunction

  // Transaction-level model: busy/age of the one outstanding request, commit when response is due.
  logic        m_busy = 1'b0;
  logic        m_done, m_w, m_err, exp_v;
  int          m_since;
  logic [63:0] m_a, m_d, m_rd;
  logic [3:0]  m_s;

  always @(negedge clk) begin
    if (!reset) begin
      m_busy = 1'b0;
      chk("ready_in_reset", 64'(req_ready), 64'd0);
      chk("valid_in_reset", 64'(resp_valid), 64'd0);
    end else begin
      if (m_busy) m_since++;
      exp_v = m_busy && (m_since >= int'(LAT) + 1);
      chk("req_ready", 64'(req_ready), 64'(!m_busy));
      chk("resp_valid", 64'(resp_valid), 64'(exp_v));
      if (exp_v) begin
        if (!m_done) begin
          m_done = 1'b1;
          m_err  = !mdl_legal(m_a, m_s);
          if (!m_err && m_w) mdl_store(m_a, m_s, m_d);
          m_rd = (m_err || m_w) ? 64'd0 : mdl_load(m_a, m_s);
        end
        chk("resp_rdata", resp_rdata, m_rd);
        chk("resp_err", 64'(resp_err), 64'(m_err));
        if (resp_ready) m_busy = 1'b0;
      end else if (!m_busy && req_valid) begin
        m_busy = 1'b1; m_since = 0; m_done = 1'b0;
        m_w = req_write; m_a = req_addr; m_s = req_size; m_d = req_wdata;
      end
    end
  end

  task automatic do_req(input logic w, input logic [63:0] a, input logic [3:0] s,
                        input logic [63:0] d, input int hold,
                        output logic [63:0] rd, output logic er, output int lat);
    logic got;
    got = 1'b0; rd = 64'd0; er = 1'b0; lat = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = s; req_wdata = d;
    resp_ready = (hold == 0) ? 1'($urandom % 2) : 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); got = req_ready;
    end
    chk("accept_seen", 64'(got), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    got = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) begin got = 1'b1; lat = i; rd = resp_rdata; er = resp_err; end
    end
    chk("resp_seen", 64'(got), 64'd1);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      req_valid = 1'($urandom % 2); req_write = 1'($urandom % 2);
      req_addr = 64'($urandom_range(0, 1023)) & ~64'd7; req_size = 4'd8;
    end
    if (!resp_ready) begin
      @(posedge clk); #1; resp_ready = 1'b1; req_valid = 1'b0;
    end
    @(posedge clk); #1;
    resp_ready = 1'b0; req_valid = 1'b0;
  endtask

  task automatic req3(input logic w, input logic [63:0] a, input logic [3:0] s,
                      input logic [63:0] d, output logic [63:0] rd, output logic er, output int lat);
    logic got;
    got = 1'b0; rd = 64'd0; er = 1'b0; lat = 0;
    @(posedge clk); #1;
    req_valid3 = 1'b1; req_write3 = w; req_addr3 = a; req_size3 = s; req_wdata3 = d;
    resp_ready3 = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); got = req_ready3;
    end
    chk("l3_accept_seen", 64'(got), 64'd1);
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    got = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (resp_valid3) begin got = 1'b1; lat = i; rd = resp_rdata3; er = resp_err3; end
    end
    chk("l3_resp_seen", 64'(got), 64'd1);
    @(posedge clk); #1;
    resp_ready3 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] rd, saved;
    logic        er, seen, acc;
    int          lat;

    reset = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h10; req_size = 4'd8;
    req_wdata = 64'hDEAD_BEEF_0000_1111; resp_ready = 1'b0;
    reset3 = 1'b0; req_valid3 = 1'b0; req_write3 = 1'b0; req_addr3 = 64'd0; req_size3 = 4'd1;
    req_wdata3 = 64'd0; resp_ready3 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("t1_ready_held", 64'(req_ready), 64'd0);
    reset = 1'b1; reset3 = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    chk("t1_ready_release", 64'(req_ready), 64'd1);

    for (int i = 0; i < DEPTH / 8; i++)
      do_req(1'b1, 64'(i * 8), 4'd8, {$urandom, $urandom}, 0, rd, er, lat);

    // Reset with a store pending must leave storage untouched.
    saved = mdl_load(64'h10, 4'd8);
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h10; req_size = 4'd8;
    req_wdata = 64'h5555_5555_5555_5555;
    repeat (5) @(posedge clk);
    #1; reset = 1'b1; req_valid = 1'b0;
    do_req(1'b0, 64'h10, 4'd8, 64'd0, 0, rd, er, lat);
    chk("t1_untouched", rd, saved);

    do_req(1'b1, 64'h10, 4'd8, 64'h0123456789ABCDEF, 0, rd, er, lat);
    chk("t2_store_err", 64'(er), 64'd0);
    chk("t2_store_lat", 64'(lat), 64'd3);
    do_req(1'b0, 64'h10, 4'd8, 64'd0, 0, rd, er, lat);
    chk("t2_load_data", rd, 64'h0123456789ABCDEF);
    chk("t2_load_err", 64'(er), 64'd0);
    chk("t2_load_lat", 64'(lat), 64'd3);

    do_req(1'b1, 64'h13, 4'd1, 64'h0000_0000_0000_00AA, 0, rd, er, lat);
    do_req(1'b0, 64'h10, 4'd8, 64'd0, 0, rd, er, lat);
    chk("t3_load8", rd, 64'h01234567AAABCDEF);
    chk("t3_model_pin", mdl_load(64'h10, 4'd8), 64'h01234567AAABCDEF);
    do_req(1'b0, 64'h12, 4'd2, 64'd0, 0, rd, er, lat);
    chk("t3_load2", rd, 64'h000000000000AAAB);

    do_req(1'b0, 64'h12, 4'd4, 64'd0, 0, rd, er, lat);
    chk("t4_misalign_err", 64'(er), 64'd1);
    chk("t4_misalign_data", rd, 64'd0);
    do_req(1'b1, 64'h400, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 0, rd, er, lat);
    chk("t4_range_err", 64'(er), 64'd1);
    do_req(1'b1, 64'h0, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 0, rd, er, lat);
    chk("t4_size_err", 64'(er), 64'd1);
    do_req(1'b0, 64'h10, 4'd8, 64'd0, 0, rd, er, lat);
    chk("t4_unchanged", rd, 64'h01234567AAABCDEF);

    do_req(1'b0, 64'h10, 4'd8, 64'd0, 4, rd, er, lat);
    chk("t5_backpressure_data", rd, 64'h01234567AAABCDEF);

    for (int k = 0; k < 300; k++) begin
      logic [3:0]  s;
      logic [63:0] a;
      s = ($urandom % 10 < 8) ? 4'(1 << ($urandom % 4)) : 4'($urandom % 16);
      case ($urandom % 8)
        0:       a = {$urandom, $urandom};
        1:       a = 64'($urandom_range(0, 1031));
        default: a = 64'($urandom_range(0, 1023)) & ~(64'(s) - 64'd1);
      endcase
      do_req(1'($urandom % 2), a, s, {$urandom, $urandom}, int'($urandom % 3), rd, er, lat);
    end

    req3(1'b1, 64'h20, 4'd1, 64'h5C, rd, er, lat);
    chk("t6_pre_err", 64'(er), 64'd0);
    chk("t6_pre_lat", 64'(lat), 64'd4);
    @(posedge clk); #1;
    req_valid3 = 1'b1; req_write3 = 1'b1; req_addr3 = 64'h20; req_size3 = 4'd1;
    req_wdata3 = 64'hFF; resp_ready3 = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk); acc = req_ready3;
    end
    chk("t6_abort_accept", 64'(acc), 64'd1);
    @(posedge clk); #1; req_valid3 = 1'b0;
    @(posedge clk); #1; reset3 = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid3) seen = 1'b1;
    end
    chk("t6_ready_in_reset", 64'(req_ready3), 64'd0);
    @(posedge clk); #1; reset3 = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid3) seen = 1'b1;
    end
    chk("t6_no_resp", 64'(seen), 64'd0);
    chk("t6_ready_after", 64'(req_ready3), 64'd1);
    req3(1'b0, 64'h20, 4'd1, 64'd0, rd, er, lat);
    chk("t6_pre_store_value", rd, 64'h5C);
    chk("t6_load_err", 64'(er), 64'd0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
